// File: rtl/time_set_ctrl_pkg.sv
// Shared types and BCD limits for the time-setting controller.
// Holds the FSM state encoding and the per-digit legality rule for 24-hour BCD entry.
package time_set_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [1:0] DIG_MS_HR  = 2'd0;
    localparam logic [1:0] DIG_LS_HR  = 2'd1;
    localparam logic [1:0] DIG_MS_MIN = 2'd2;
    localparam logic [1:0] DIG_LS_MIN = 2'd3;

    localparam logic [3:0] MAX_MS_HR     = 4'd2;
    localparam logic [3:0] MAX_LS_HR_20S = 4'd3;
    localparam logic [3:0] MAX_MS_MIN    = 4'd5;
    localparam logic [3:0] MAX_BCD       = 4'd9;

    // The hours units digit tightens to 3 only once the tens digit is 2 (20..23).
    function automatic logic digitLegal(input logic [1:0] idx,
                                        input logic [3:0] msHr,
                                        input logic [3:0] key);
        logic [3:0] limit;
        case (idx)
            DIG_MS_HR:  limit = MAX_MS_HR;
            DIG_LS_HR:  limit = (msHr == MAX_MS_HR) ? MAX_LS_HR_20S : MAX_BCD;
            DIG_MS_MIN: limit = MAX_MS_MIN;
            default:    limit = MAX_BCD;
        endcase
        return (key <= limit);
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Keypad/counter-side signal bundle of the time-setting controller.
// The controller is the slave; the keypad scanner and minute/hour counter form the master side.
interface time_set_ctrl_if;

    logic        set_time;
    logic        cancel;
    logic        key_valid;
    logic [3:0]  key;
    logic [15:0] new_current_time;
    logic        load_new_c;
    logic        one_minute;
    logic        entry_active;
    logic [1:0]  digit_idx;
    logic        entry_error;

    modport master (
        output set_time, cancel, key_valid, key,
        input  new_current_time, load_new_c, one_minute, entry_active, digit_idx, entry_error
    );

    modport slave (
        input  set_time, cancel, key_valid, key,
        output new_current_time, load_new_c, one_minute, entry_active, digit_idx, entry_error
    );

endinterface

// File: rtl/time_set_ctrl_minute_timebase.sv
// Free-running minute prescaler with a synchronous clear; one_minute is high while the
// prescaler sits at its last count, unless the caller masks it for the coming cycle.
module minute_timebase #(
    parameter int TICKS_PER_MIN = 15360
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_mask,
    output logic o_one_minute
);

    localparam int              W    = $clog2(TICKS_PER_MIN);
    localparam logic [W-1:0]    LAST = W'(TICKS_PER_MIN - 1);

    logic [W-1:0] r_count;
    logic         r_oneMinute;
    logic [W-1:0] w_countNext;

    always_comb begin
        w_countNext = r_count + W'(1);
        if (i_clear || (r_count == LAST)) begin
            w_countNext = '0;
        end
    end

    // The pulse is registered from the next count so it lines up with the wrap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_oneMinute <= 1'b0;
        end else begin
            r_count     <= w_countNext;
            r_oneMinute <= (w_countNext == LAST) && !i_mask;
        end
    end

    assign o_one_minute = r_oneMinute;

endmodule

// File: rtl/time_set_ctrl.sv
// Builds a 4-digit BCD 24-hour time from keypad digits and pulses load_new_c to the counter;
// also owns the minute timebase, which restarts a full minute after every load.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int TICKS_PER_MIN = 15360,
    parameter int TIMEOUT_TICKS = 2560
) (
    input  logic            clk,
    input  logic            rst_n,
    time_set_ctrl_if.slave  bus
);

    localparam int            TW           = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);

    state_t        r_state;
    logic [15:0]   r_staging;
    logic [1:0]    r_digitIdx;
    logic [TW-1:0] r_timeout;
    logic          r_loadNewC;
    logic          r_entryError;
    logic          r_entryActive;

    logic          w_digitLegal;
    logic          w_toLoad;
    logic          w_oneMinute;

    assign w_digitLegal = digitLegal(r_digitIdx, r_staging[15:12], bus.key);

    // Entering LOAD must also silence the minute pulse for that cycle.
    assign w_toLoad = (r_state == ENTRY) && !bus.cancel && !bus.set_time &&
                      bus.key_valid && w_digitLegal && (r_digitIdx == DIG_LS_MIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_staging     <= '0;
            r_digitIdx    <= DIG_MS_HR;
            r_timeout     <= '0;
            r_loadNewC    <= 1'b0;
            r_entryError  <= 1'b0;
            r_entryActive <= 1'b0;
        end else begin
            r_loadNewC   <= 1'b0;
            r_entryError <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.set_time) begin
                        r_state       <= ENTRY;
                        r_staging     <= '0;
                        r_digitIdx    <= DIG_MS_HR;
                        r_timeout     <= '0;
                        r_entryActive <= 1'b1;
                    end
                end
                ENTRY: begin
                    if (bus.cancel) begin
                        r_state       <= IDLE;
                        r_entryActive <= 1'b0;
                    end else if (bus.set_time) begin
                        r_staging  <= '0;
                        r_digitIdx <= DIG_MS_HR;
                        r_timeout  <= '0;
                    end else if (bus.key_valid) begin
                        // A rejected digit leaves the timeout counter untouched.
                        if (w_digitLegal) begin
                            case (r_digitIdx)
                                DIG_MS_HR:  r_staging[15:12] <= bus.key;
                                DIG_LS_HR:  r_staging[11:8]  <= bus.key;
                                DIG_MS_MIN: r_staging[7:4]   <= bus.key;
                                default:    r_staging[3:0]   <= bus.key;
                            endcase
                            r_digitIdx <= r_digitIdx + 2'd1;
                            r_timeout  <= '0;
                            if (r_digitIdx == DIG_LS_MIN) begin
                                r_state       <= LOAD;
                                r_loadNewC    <= 1'b1;
                                r_entryActive <= 1'b0;
                            end
                        end else begin
                            r_entryError <= 1'b1;
                        end
                    end else if (r_timeout == TIMEOUT_LAST) begin
                        r_state       <= IDLE;
                        r_entryActive <= 1'b0;
                        r_entryError  <= 1'b1;
                    end else begin
                        r_timeout <= r_timeout + TW'(1);
                    end
                end
                LOAD: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state       <= IDLE;
                    r_entryActive <= 1'b0;
                end
            endcase
        end
    end

    minute_timebase #(
        .TICKS_PER_MIN (TICKS_PER_MIN)
    ) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (r_state == LOAD),
        .i_mask       (w_toLoad),
        .o_one_minute (w_oneMinute)
    );

    assign bus.new_current_time = r_staging;
    assign bus.load_new_c       = r_loadNewC;
    assign bus.one_minute       = w_oneMinute;
    assign bus.entry_active     = r_entryActive;
    assign bus.digit_idx        = r_digitIdx;
    assign bus.entry_error      = r_entryError;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a cycle-level time-entry model predicts load, error and
// minute pulses into queues, and an independent monitor matches them against the DUT.
module tb_time_set_ctrl;

    localparam int TICKS   = 10;
    localparam int TIMEOUT = 20;

    typedef struct {
        int          stamp;
        logic [15:0] value;
    } loadEv_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc;
    int   total = 0;
    int   bad   = 0;

    loadEv_t loadQ[$];
    int      errQ[$];
    int      minQ[$];

    bit mEntry;
    bit mLoad;
    int mIdx;
    int mIdle;
    int mZero;
    int mDig[4];

    always #5 clk = ~clk;

    time_set_ctrl_if bus();

    time_set_ctrl #(
        .TICKS_PER_MIN (TICKS),
        .TIMEOUT_TICKS (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic compare(input string name, input int actual, input int required);
        total++;
        if (actual != required) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    function automatic logic [15:0] staging();
        return 16'((mDig[0] << 12) | (mDig[1] << 8) | (mDig[2] << 4) | mDig[3]);
    endfunction

    // A digit is legal when the time it builds (later digits taken as 0) is a real 24h time.
    function automatic bit legalDigit(input int idx, input int key);
        int d[4];
        if (key > 9) return 1'b0;
        d = mDig;
        d[idx] = key;
        for (int i = idx + 1; i < 4; i++) d[i] = 0;
        return ((d[0] * 10 + d[1]) < 24) && ((d[2] * 10 + d[3]) < 60);
    endfunction

    function automatic int pickLegal();
        int hi = 9;
        while (hi > 0 && !legalDigit(mIdx, hi)) hi--;
        return int'($urandom_range(0, hi));
    endfunction

    function automatic void resetModel();
        mEntry = 1'b0;
        mLoad  = 1'b0;
        mIdx   = 0;
        mIdle  = 0;
        mZero  = 0;
        for (int i = 0; i < 4; i++) mDig[i] = 0;
    endfunction

    function automatic void beginEntry();
        mEntry = 1'b1;
        mIdx   = 0;
        mIdle  = 0;
        for (int i = 0; i < 4; i++) mDig[i] = 0;
    endfunction

    // Advances the model by one cycle given this cycle's inputs; events land on the next cycle.
    function automatic void modelStep(input bit s, input bit c, input bit kv, input int k);
        int now      = cyc;
        bit nextLoad = 1'b0;
        if (mLoad) begin
            mLoad = 1'b0;
            mZero = now + 1;
        end else if (mEntry) begin
            if (c) begin
                mEntry = 1'b0;
            end else if (s) begin
                beginEntry();
            end else if (kv) begin
                if (legalDigit(mIdx, k)) begin
                    mDig[mIdx] = k;
                    mIdle = 0;
                    if (mIdx == 3) begin
                        mEntry   = 1'b0;
                        mLoad    = 1'b1;
                        nextLoad = 1'b1;
                        mIdx     = 0;
                        loadQ.push_back('{now + 1, staging()});
                    end else begin
                        mIdx++;
                    end
                end else begin
                    errQ.push_back(now + 1);
                end
            end else if (mIdle == TIMEOUT - 1) begin
                mEntry = 1'b0;
                errQ.push_back(now + 1);
            end else begin
                mIdle++;
            end
        end else if (s) begin
            beginEntry();
        end
        if (!nextLoad && (((now + 1 - mZero) % TICKS) == TICKS - 1)) minQ.push_back(now + 1);
    endfunction

    task automatic applyStimulus(input bit s, input bit c, input bit kv, input int k);
        @(negedge clk);
        bus.set_time  = s;
        bus.cancel    = c;
        bus.key_valid = kv;
        bus.key       = 4'(k);
        modelStep(s, c, kv, k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic keys(input int a, input int b, input int c, input int d);
        applyStimulus(1'b0, 1'b0, 1'b1, a);
        applyStimulus(1'b0, 1'b0, 1'b1, b);
        applyStimulus(1'b0, 1'b0, 1'b1, c);
        applyStimulus(1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic checkOutput(input string name);
        @(negedge clk);
        compare({name, "_entry_active"}, int'(bus.entry_active), int'(mEntry));
        compare({name, "_digit_idx"}, int'(bus.digit_idx), mIdx % 4);
        compare({name, "_new_time"}, int'(bus.new_current_time), int'(staging()));
        bus.set_time  = 1'b0;
        bus.cancel    = 1'b0;
        bus.key_valid = 1'b0;
        bus.key       = 4'd0;
        modelStep(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic checkResetOutputs();
        @(negedge clk);
        compare("rst_new_time", int'(bus.new_current_time), 0);
        compare("rst_load", int'(bus.load_new_c), 0);
        compare("rst_minute", int'(bus.one_minute), 0);
        compare("rst_entry_active", int'(bus.entry_active), 0);
        compare("rst_digit_idx", int'(bus.digit_idx), 0);
        compare("rst_entry_error", int'(bus.entry_error), 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        #1;
        rst_n         = 1'b0;
        bus.set_time  = 1'b0;
        bus.cancel    = 1'b0;
        bus.key_valid = 1'b0;
        bus.key       = 4'd0;
        loadQ.delete();
        errQ.delete();
        minQ.delete();
        resetModel();
        checkResetOutputs();
        checkResetOutputs();
        @(negedge clk);
        rst_n = 1'b1;
        modelStep(1'b0, 1'b0, 1'b0, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (loadQ.size() > 0 && loadQ[0].stamp < cyc) begin
                compare("load_missing", cyc, loadQ[0].stamp);
                void'(loadQ.pop_front());
            end
            while (errQ.size() > 0 && errQ[0] < cyc) begin
                compare("error_missing", cyc, errQ[0]);
                void'(errQ.pop_front());
            end
            while (minQ.size() > 0 && minQ[0] < cyc) begin
                compare("minute_missing", cyc, minQ[0]);
                void'(minQ.pop_front());
            end
            if (bus.load_new_c) begin
                if (loadQ.size() == 0) begin
                    compare("load_unexpected", cyc, -1);
                end else begin
                    loadEv_t ev;
                    ev = loadQ.pop_front();
                    compare("load_cycle", cyc, ev.stamp);
                    compare("load_value", int'(bus.new_current_time), int'(ev.value));
                end
            end
            if (bus.entry_error) begin
                if (errQ.size() == 0) compare("error_unexpected", cyc, -1);
                else                  compare("error_cycle", cyc, errQ.pop_front());
            end
            if (bus.one_minute) begin
                if (minQ.size() == 0) compare("minute_unexpected", cyc, -1);
                else                  compare("minute_cycle", cyc, minQ.pop_front());
            end
        end
    end

    initial begin
        bus.set_time  = 1'b0;
        bus.cancel    = 1'b0;
        bus.key_valid = 1'b0;
        bus.key       = 4'd0;
        resetModel();
        checkResetOutputs();
        @(negedge clk);
        rst_n = 1'b1;
        modelStep(1'b0, 1'b0, 1'b0, 0);

        $display("[TB] basic entry 17:45");
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        keys(1, 7, 4, 5);
        checkOutput("t1");

        $display("[TB] rejected digit then 23:59");
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 4);
        checkOutput("t2_after_reject");
        applyStimulus(1'b0, 1'b0, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 5);
        applyStimulus(1'b0, 1'b0, 1'b1, 9);
        checkOutput("t2_done");

        $display("[TB] cancel mid entry");
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8);
        applyStimulus(1'b0, 1'b1, 1'b0, 0);
        checkOutput("t3");

        $display("[TB] timeout abort");
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        idle(TIMEOUT);
        checkOutput("t4");

        $display("[TB] priority and illegal codes");
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 2);
        checkOutput("prio_restart");
        applyStimulus(1'b0, 1'b1, 1'b1, 1);
        checkOutput("prio_cancel");
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 15);
        applyStimulus(1'b0, 1'b0, 1'b1, 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 1'b1, 6);
        applyStimulus(1'b0, 1'b0, 1'b1, 5);
        applyStimulus(1'b0, 1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 1'b1, 9);
        applyStimulus(1'b1, 1'b1, 1'b1, 3);
        checkOutput("prio_after_load");

        $display("[TB] randomized traffic");
        for (int t = 0; t < 700; t++) begin
            int r = int'($urandom_range(0, 99));
            if (!mEntry && r < 40)  applyStimulus(1'b1, 1'b0, 1'b0, 0);
            else if (r < 4)         applyStimulus(1'b1, 1'b0, 1'b0, 0);
            else if (r < 7)         applyStimulus(1'b0, 1'b1, 1'b0, 0);
            else if (r < 17)        applyStimulus(1'b0, 1'b0, 1'b1, int'($urandom_range(0, 15)));
            else if (r < 60)        applyStimulus(1'b0, 1'b0, 1'b1, pickLegal());
            else if (r < 62)        idle(TIMEOUT + 2);
            else if (r < 66)        checkOutput("rand");
            else                    idle(1);
        end

        $display("[TB] minute timebase around a load");
        doReset();
        idle(13);
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        keys(1, 2, 3, 4);
        idle(15);
        checkOutput("t5");

        $display("[TB] reset between third and fourth key");
        applyStimulus(1'b1, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 3);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 4);
        idle(3);
        checkOutput("t6");

        idle(TICKS + 2);
        @(negedge clk);
        foreach (loadQ[i]) compare("load_never_seen", cyc, loadQ[i].stamp);
        foreach (errQ[i])  compare("error_never_seen", cyc, errQ[i]);
        foreach (minQ[i])  compare("minute_never_seen", cyc, minQ[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
